// File: rtl/bus_fifo_port_pkg.sv
// Shared definitions for bus_fifo_port: sub-bus field positions, register
// offsets and STATUS bit positions.
package bus_fifo_port_pkg;

    // Sub-bus request layout: {addr[31:0], be[3:0], wr_data[31:0], rd_req, wr_req}
    localparam int BUS_IN_WIDTH  = 70;
    localparam int BI_WR_REQ     = 0;
    localparam int BI_RD_REQ     = 1;
    localparam int BI_WDATA_LSB  = 2;
    localparam int BI_BE_LSB     = 34;
    localparam int BI_ADDR_LSB   = 38;

    // Sub-bus response layout: {rd_data[31:0], rd_ack}
    localparam int BUS_OUT_WIDTH = 33;
    localparam int BO_RD_ACK     = 0;
    localparam int BO_RDATA_LSB  = 1;

    // Register offsets within the 16-byte block
    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_THRESH = 4'h8;

    // STATUS bit positions
    localparam int ST_TX_CNT_LSB = 0;
    localparam int ST_RX_CNT_LSB = 8;
    localparam int ST_TX_FULL    = 16;
    localparam int ST_RX_EMPTY   = 17;
    localparam int ST_TX_OVF     = 18;
    localparam int ST_RX_UNF     = 19;

    // A count of up to 256 is shown in one byte; 256 wraps to 0 and the
    // full/empty flags disambiguate it.
    function automatic logic [7:0] count_byte(input logic [8:0] cnt);
        return cnt[7:0];
    endfunction

endpackage

// File: rtl/bus_fifo_core.sv
// Synchronous FIFO with extra-MSB pointers; head is shown combinationally.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module bus_fifo_core #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    // Pointer advance on accepted push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + CW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + CW'(1);
    end

    // Pointer registers; reset empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/bus_fifo_port.sv
// Bus slave exposing a TX FIFO (bus writes -> stream) and an RX FIFO
// (stream -> bus reads) through DATA and STATUS registers.
// Optional build macro BUS_FIFO_PORT_IRQ_EN adds the THRESH register and irq.
module bus_fifo_port
    import bus_fifo_port_pkg::*;
#(
    parameter logic [31:0] BUS_ADDR   = 32'h0,
    parameter int          DEPTH_LOG2 = 4,
    parameter int          DATA_WIDTH = 32
) (
    input  logic                     bus_clk,
    input  logic                     bus_reset_l,
    input  logic [BUS_IN_WIDTH-1:0]  bus_in,
    output logic [BUS_OUT_WIDTH-1:0] bus_out,
    output logic [DATA_WIDTH-1:0]    tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    input  logic [DATA_WIDTH-1:0]    rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready
`ifdef BUS_FIFO_PORT_IRQ_EN
    ,
    output logic                     irq
`endif
);

    localparam int CW = DEPTH_LOG2 + 1;

    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rd_req;
    logic        wr_req;
    logic        unused_bus;

    assign addr   = bus_in[BI_ADDR_LSB +: 32];
    assign be     = bus_in[BI_BE_LSB +: 4];
    assign wdata  = bus_in[BI_WDATA_LSB +: 32];
    assign rd_req = bus_in[BI_RD_REQ];
    assign wr_req = bus_in[BI_WR_REQ];
    assign unused_bus = ^{addr[1:0], be, wdata};

    logic       hit;
    logic [3:0] reg_off;
    logic       sel_data;
    logic       sel_status;

    assign hit        = (addr[31:4] == BUS_ADDR[31:4]);
    assign reg_off    = {addr[3:2], 2'b00};
    assign sel_data   = hit && (reg_off == REG_DATA);
    assign sel_status = hit && (reg_off == REG_STATUS);

    logic wr_data_hit;
    logic rd_data_hit;

    assign wr_data_hit = wr_req && sel_data;
    assign rd_data_hit = rd_req && sel_data;

    logic                  tx_full, tx_empty;
    logic [CW-1:0]         tx_count;
    logic                  rx_full, rx_empty;
    logic [CW-1:0]         rx_count;
    logic [DATA_WIDTH-1:0] rx_head;

    bus_fifo_core #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tx_fifo (
        .clk         (bus_clk),
        .rst_n       (bus_reset_l),
        .push_i      (wr_data_hit),
        .push_data_i (wdata[DATA_WIDTH-1:0]),
        .pop_i       (tx_valid && tx_ready),
        .head_o      (tx_data),
        .full_o      (tx_full),
        .empty_o     (tx_empty),
        .count_o     (tx_count)
    );

    bus_fifo_core #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rx_fifo (
        .clk         (bus_clk),
        .rst_n       (bus_reset_l),
        .push_i      (rx_valid && rx_ready),
        .push_data_i (rx_data),
        .pop_i       (rd_data_hit),
        .head_o      (rx_head),
        .full_o      (rx_full),
        .empty_o     (rx_empty),
        .count_o     (rx_count)
    );

    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full;

    logic tx_ovf_q, tx_ovf_d;
    logic rx_unf_q, rx_unf_d;
    logic tx_ovf_clr, rx_unf_clr;

    assign tx_ovf_clr = wr_req && sel_status && be[2] && wdata[ST_TX_OVF];
    assign rx_unf_clr = wr_req && sel_status && be[2] && wdata[ST_RX_UNF];

    // Sticky error flags: W1C clear first, so a same-cycle set wins
    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_unf_d = rx_unf_q;
        if (tx_ovf_clr) tx_ovf_d = 1'b0;
        if (rx_unf_clr) rx_unf_d = 1'b0;
        if (wr_data_hit && tx_full)  tx_ovf_d = 1'b1;
        if (rd_data_hit && rx_empty) rx_unf_d = 1'b1;
    end

`ifdef BUS_FIFO_PORT_IRQ_EN
    logic          sel_thresh;
    logic [CW-1:0] thresh_q, thresh_d;
    logic          irq_q, irq_d;

    assign sel_thresh = hit && (reg_off == REG_THRESH);

    // Threshold register write and registered interrupt cause
    always_comb begin
        thresh_d = thresh_q;
        if (wr_req && sel_thresh) thresh_d = wdata[CW-1:0];
        irq_d = ((thresh_q != '0) && (rx_count >= thresh_q)) || tx_ovf_q || rx_unf_q;
    end

    // IRQ state registers
    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            thresh_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            thresh_q <= thresh_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    logic [31:0] status_word;
    logic [31:0] rd_mux;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_ack_q, rd_ack_d;

    // STATUS assembly and read-data selection; an empty RX pop reads 0
    always_comb begin
        status_word = '0;
        status_word[ST_TX_CNT_LSB +: 8] = count_byte(9'(tx_count));
        status_word[ST_RX_CNT_LSB +: 8] = count_byte(9'(rx_count));
        status_word[ST_TX_FULL]         = tx_full;
        status_word[ST_RX_EMPTY]        = rx_empty;
        status_word[ST_TX_OVF]          = tx_ovf_q;
        status_word[ST_RX_UNF]          = rx_unf_q;

        rd_mux = '0;
        case (reg_off)
            REG_DATA:   if (!rx_empty) rd_mux = 32'(rx_head);
            REG_STATUS: rd_mux = status_word;
`ifdef BUS_FIFO_PORT_IRQ_EN
            REG_THRESH: rd_mux = 32'(thresh_q);
`endif
            default:    rd_mux = '0;
        endcase

        rd_ack_d  = rd_req && hit;
        rd_data_d = rd_ack_d ? rd_mux : '0;
    end

    // Read response pipeline and sticky flag registers
    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
            tx_ovf_q  <= 1'b0;
            rx_unf_q  <= 1'b0;
        end else begin
            rd_ack_q  <= rd_ack_d;
            rd_data_q <= rd_data_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_unf_q  <= rx_unf_d;
        end
    end

    // Response packing; fields not listed stay 0
    always_comb begin
        bus_out = '0;
        bus_out[BO_RD_ACK]         = rd_ack_q;
        bus_out[BO_RDATA_LSB +: 32] = rd_data_q;
    end

endmodule

// File: tb/tb_bus_fifo_port.sv
// Self-checking bench for bus_fifo_port: register vector table, TX/RX
// scoreboards, wrap with random stalls, async reset mid-transfer.
`timescale 1ns/1ps
module tb_bus_fifo_port;
    import bus_fifo_port_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_0040;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_l = 1'b1;
    logic [31:0] b_addr = '0;
    logic [31:0] b_wdata = '0;
    logic [3:0]  b_be = '0;
    logic        b_rd = 1'b0;
    logic        b_wr = 1'b0;
    logic [BUS_IN_WIDTH-1:0]  bus_in;
    logic [BUS_OUT_WIDTH-1:0] bus_out;
    logic [31:0] tx_data;
    logic [31:0] rx_data = '0;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        rd_ack;
    logic [31:0] rd_data;
`ifdef BUS_FIFO_PORT_IRQ_EN
    logic        irq;
`endif

    assign bus_in  = {b_addr, b_be, b_wdata, b_rd, b_wr};
    assign rd_ack  = bus_out[BO_RD_ACK];
    assign rd_data = bus_out[BO_RDATA_LSB +: 32];

    always #5 clk = ~clk;

    bus_fifo_port #(
        .BUS_ADDR   (BASE),
        .DEPTH_LOG2 (4),
        .DATA_WIDTH (32)
    ) dut (
        .bus_clk     (clk),
        .bus_reset_l (rst_l),
        .bus_in      (bus_in),
        .bus_out     (bus_out),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready)
`ifdef BUS_FIFO_PORT_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    bit          saw_rx_full = 1'b0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        bit          exp_ack;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Stream-side scoreboard: invariants first, then TX pop compare and RX capture
    always @(negedge clk) begin
        if (rst_l) begin
            chk("tx_valid_vs_model", 32'(tx_valid), 32'(tx_q.size() != 0));
            chk("rx_ready_vs_model", 32'(rx_ready), 32'(rx_q.size() != DEPTH));
            if (!rx_ready) saw_rx_full = 1'b1;
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_extra_beat actual=%h expected=none", tx_data);
                end else begin
                    chk("tx_stream_data", tx_data, tx_q.pop_front());
                end
            end
            if (rx_valid && rx_ready) rx_q.push_back(rx_data);
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        bit is_data;
        bit full_pre;
        @(posedge clk); #1;
        b_addr = a; b_be = be; b_wdata = d; b_wr = 1'b1;
        is_data  = (a[31:4] == BASE[31:4]) && (a[3:2] == 2'd0);
        full_pre = (tx_q.size() >= DEPTH);
        @(posedge clk);
        if (is_data && !full_pre) tx_q.push_back(d);
        #1;
        b_wr = 1'b0;
    endtask

    // pop_rx: DATA read, expectation taken from the RX model at request time
    task automatic bus_read(input string nm, input logic [31:0] a, input bit exp_ack,
                            input logic [31:0] exp, input bit pop_rx);
        logic [31:0] e;
        bit          empty_pre;
        @(posedge clk); #1;
        b_addr = a; b_rd = 1'b1;
        empty_pre = (rx_q.size() == 0);
        e = exp;
        if (pop_rx) e = empty_pre ? 32'h0 : rx_q[0];
        @(posedge clk);
        if (pop_rx && !empty_pre) void'(rx_q.pop_front());
        #1;
        b_rd = 1'b0;
        chk({nm, "_ack"}, 32'(rd_ack), 32'(exp_ack));
        if (exp_ack) chk({nm, "_data"}, rd_data, e);
        @(posedge clk); #1;
        chk({nm, "_ack_one_cycle"}, 32'(rd_ack), 32'h0);
    endtask

    task automatic rx_send(input logic [31:0] d);
        int g;
        g = 0;
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = d;
        @(negedge clk);
        while (!rx_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("rx_send_accepted", 32'(rx_ready), 32'h1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx_drain(input string nm);
        int g;
        g = 0;
        while (tx_q.size() != 0 && g < 1000) begin
            @(posedge clk);
            g++;
        end
        @(posedge clk); #1;
        chk(nm, 32'(tx_valid), 32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1'b0, BASE + 32'h4, 4'h0, 32'h0,         1'b1, 32'h0002_0000};
        vt[1]  = '{1'b0, BASE + 32'h8, 4'h0, 32'h0,         1'b1, 32'h0};
        vt[2]  = '{1'b0, BASE + 32'hC, 4'h0, 32'h0,         1'b1, 32'h0};
        vt[3]  = '{1'b1, BASE + 32'hC, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0};
        vt[4]  = '{1'b0, BASE + 32'h4, 4'h0, 32'h0,         1'b1, 32'h0002_0000};
        vt[5]  = '{1'b0, 32'h0000_0080, 4'h0, 32'h0,        1'b0, 32'h0};
        vt[6]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h0000_DEAD, 1'b0, 32'h0};
        vt[7]  = '{1'b1, BASE,          4'h0, 32'h0000_00A5, 1'b0, 32'h0};
        vt[8]  = '{1'b1, BASE,          4'hF, 32'h0000_005A, 1'b0, 32'h0};
        vt[9]  = '{1'b0, BASE + 32'h4, 4'h0, 32'h0,         1'b1, 32'h0002_0002};
        vt[10] = '{1'b0, 32'h0000_0054, 4'h0, 32'h0,        1'b0, 32'h0};

        // Reset state
        #2 rst_l = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_rx_ready", 32'(rx_ready), 32'h1);
        chk("rst_bus_out",  32'(bus_out),  32'h0);
        rst_l = 1'b1;

        // Register vectors with the stream stalled
        for (int i = 0; i < 11; i++) begin
            if (vt[i].wr) bus_write(vt[i].addr, vt[i].be, vt[i].data);
            else          bus_read($sformatf("vec%0d", i), vt[i].addr, vt[i].exp_ack, vt[i].exp, 1'b0);
        end

        // Two queued words leave on consecutive beats
        @(posedge clk); #1;
        tx_ready = 1'b1;
        @(negedge clk);
        chk("t1_beat0", tx_data, 32'h0000_00A5);
        @(negedge clk);
        chk("t1_beat1", tx_data, 32'h0000_005A);
        wait_tx_drain("t1_tx_valid_low");
        bus_read("t1_status", BASE + 32'h4, 1'b1, 32'h0002_0000, 1'b0);

        // Overflow on the 17th word, then W1C
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) bus_write(BASE, 4'hF, 32'h100 + i);
        bus_read("t2_status_full", BASE + 32'h4, 1'b1, 32'h0007_0010, 1'b0);
        bus_write(BASE + 32'h4, 4'b1011, 32'h0004_0000);
        bus_read("t2_w1c_be_gated", BASE + 32'h4, 1'b1, 32'h0007_0010, 1'b0);
        bus_write(BASE + 32'h4, 4'b0100, 32'h0004_0000);
        bus_read("t2_w1c_cleared", BASE + 32'h4, 1'b1, 32'h0003_0010, 1'b0);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        wait_tx_drain("t2_drained");

        // RX path and underflow
        rx_send(32'h11);
        rx_send(32'h22);
        bus_read("t3_rd0", BASE, 1'b1, 32'h0, 1'b1);
        bus_read("t3_rd1", BASE, 1'b1, 32'h0, 1'b1);
        bus_read("t3_rd_empty", BASE, 1'b1, 32'h0, 1'b1);
        bus_read("t3_status_unf", BASE + 32'h4, 1'b1, 32'h000A_0000, 1'b0);
        bus_write(BASE + 32'h4, 4'b0100, 32'h0008_0000);
        bus_read("t3_unf_cleared", BASE + 32'h4, 1'b1, 32'h0002_0000, 1'b0);

        // TX wrap with random consumer stalls
        begin : tx_wrap
            bit wr_done;
            wr_done = 1'b0;
            fork
                begin
                    int g;
                    for (int i = 0; i < 40; i++) begin
                        g = 0;
                        while (tx_q.size() >= DEPTH && g < 500) begin
                            @(posedge clk);
                            g++;
                        end
                        bus_write(BASE, 4'hF, 32'h2000 + i);
                    end
                    wr_done = 1'b1;
                end
                begin
                    int g;
                    g = 0;
                    while (!wr_done && g < 5000) begin
                        @(posedge clk); #1;
                        tx_ready = 1'($urandom_range(0, 1));
                        g++;
                    end
                    tx_ready = 1'b1;
                end
            join
        end
        wait_tx_drain("t4_tx_wrap_drained");
        bus_read("t4_tx_status", BASE + 32'h4, 1'b1, 32'h0002_0000, 1'b0);

        // RX wrap: producer fills to 16 first, then random reads drain it
        saw_rx_full = 1'b0;
        fork
            begin
                int i;
                int g;
                i = 0;
                g = 0;
                while (i < 40 && g < 5000) begin
                    @(posedge clk); #1;
                    if ($urandom_range(0, 3) == 0) rx_valid = 1'b0;
                    else begin
                        rx_valid = 1'b1;
                        rx_data  = 32'h3000 + i;
                    end
                    @(negedge clk);
                    if (rx_valid && rx_ready) i++;
                    g++;
                end
                @(posedge clk); #1;
                rx_valid = 1'b0;
            end
            begin
                int got;
                int g;
                got = 0;
                g = 0;
                repeat (40) @(posedge clk);
                while (got < 40 && g < 5000) begin
                    if (rx_q.size() != 0 && $urandom_range(0, 2) != 0) begin
                        bus_read("t4_rx_wrap", BASE, 1'b1, 32'h0, 1'b1);
                        got++;
                    end else begin
                        @(posedge clk);
                    end
                    g++;
                end
            end
        join
        chk("t4_rx_ready_dropped", 32'(saw_rx_full), 32'h1);
        bus_read("t4_rx_status", BASE + 32'h4, 1'b1, 32'h0002_0000, 1'b0);

        // Asynchronous reset with TX data queued and a read ack outstanding
        tx_ready = 1'b0;
        bus_write(BASE, 4'hF, 32'h77);
        bus_write(BASE, 4'hF, 32'h88);
        rx_send(32'h99);
        @(posedge clk); #1;
        b_addr = BASE + 32'h4; b_rd = 1'b1;
        @(posedge clk); #1;
        b_rd = 1'b0;
        chk("t5_ack_pending", 32'(rd_ack), 32'h1);
        chk("t5_tx_valid_pre", 32'(tx_valid), 32'h1);
        #1 rst_l = 1'b0;
        #1;
        chk("t5_tx_valid_async", 32'(tx_valid), 32'h0);
        chk("t5_rd_ack_async", 32'(rd_ack), 32'h0);
        chk("t5_rd_data_async", rd_data, 32'h0);
        tx_q.delete();
        rx_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_l = 1'b1;
        bus_read("t5_status_after", BASE + 32'h4, 1'b1, 32'h0002_0000, 1'b0);

`ifdef BUS_FIFO_PORT_IRQ_EN
        // RX level threshold interrupt
        bus_write(BASE + 32'h8, 4'hF, 32'h3);
        rx_send(32'h1);
        rx_send(32'h2);
        rx_send(32'h3);
        @(posedge clk); #1;
        chk("t6_irq_set", 32'(irq), 32'h1);
        bus_read("t6_rd", BASE, 1'b1, 32'h0, 1'b1);
        chk("t6_irq_clear", 32'(irq), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
